// File: rtl/test_report_tx.sv
// -----------------------------------------------------------------------------
// test_report_tx
//
// Purpose:
//   Serialises one test-result report frame to a host over a UART line
//   (8N1, idle high). A frame is the sync byte 0xA5, ICNumber
//   (most significant byte first), {2'b00,pass_vec}, {2'b00,fail_vec} and
//   {6'b0,fail,pass}. If REPORT_CHECKSUM_EN is defined, a ninth byte is
//   appended: the XOR of all the bytes before it.
//
//   All report inputs are snapshotted on the clock edge that accepts start.
//   The frame is always built from that snapshot, so later input changes do
//   not affect a frame in flight. A start that arrives while busy is dropped.
//
// Configuration:
//   CLKS_PER_BIT        clock cycles per UART bit (2..65535).
//   REPORT_CHECKSUM_EN  (macro) appends the XOR checksum byte.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      frame request, honoured only while idle
//   ICNumber   IC type under test (32 bits)
//   pass_vec   per-gate pass flags {pass6..pass1}
//   fail_vec   per-gate fail flags {fail6..fail1}
//   pass       overall pass flag
//   fail       overall fail flag
//   tx         UART serial output (registered)
//   busy       high while a frame is being sent (registered)
//   done       one-cycle pulse when the last stop bit ends (registered)
// -----------------------------------------------------------------------------
module test_report_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ICNumber,
  input  logic [5:0]  pass_vec,
  input  logic [5:0]  fail_vec,
  input  logic        pass,
  input  logic        fail,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef REPORT_CHECKSUM_EN
  localparam logic [3:0]  LAST_BYTE = 4'd8;
`else
  localparam logic [3:0]  LAST_BYTE = 4'd7;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  byte_idx_reg, byte_idx_next;
  logic        capture;

  logic [31:0] ic_snap_reg;
  logic [5:0]  pass_vec_snap_reg;
  logic [5:0]  fail_vec_snap_reg;
  logic        pass_snap_reg;
  logic        fail_snap_reg;

  logic        tx_reg, tx_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic        baud_wrap;
  logic [7:0]  cur_byte;

  assign baud_wrap = (baud_cnt_reg == BAUD_LAST);

`ifdef REPORT_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = 8'hA5 ^ ic_snap_reg[31:24] ^ ic_snap_reg[23:16]
                  ^ ic_snap_reg[15:8] ^ ic_snap_reg[7:0]
                  ^ {2'b00, pass_vec_snap_reg} ^ {2'b00, fail_vec_snap_reg}
                  ^ {6'b0, fail_snap_reg, pass_snap_reg};
`endif

  // Byte currently on the wire, chosen from the snapshot by the byte index.
  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx_reg)
      4'd0:    cur_byte = 8'hA5;
      4'd1:    cur_byte = ic_snap_reg[31:24];
      4'd2:    cur_byte = ic_snap_reg[23:16];
      4'd3:    cur_byte = ic_snap_reg[15:8];
      4'd4:    cur_byte = ic_snap_reg[7:0];
      4'd5:    cur_byte = {2'b00, pass_vec_snap_reg};
      4'd6:    cur_byte = {2'b00, fail_vec_snap_reg};
      4'd7:    cur_byte = {6'b0, fail_snap_reg, pass_snap_reg};
`ifdef REPORT_CHECKSUM_EN
      4'd8:    cur_byte = checksum;
`endif
      default: cur_byte = 8'hA5;
    endcase
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      baud_cnt_reg      <= 16'd0;
      bit_cnt_reg       <= 3'd0;
      byte_idx_reg      <= 4'd0;
      ic_snap_reg       <= 32'd0;
      pass_vec_snap_reg <= 6'd0;
      fail_vec_snap_reg <= 6'd0;
      pass_snap_reg     <= 1'b0;
      fail_snap_reg     <= 1'b0;
      tx_reg            <= 1'b1;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_idx_reg <= byte_idx_next;
      if (capture) begin
        ic_snap_reg       <= ICNumber;
        pass_vec_snap_reg <= pass_vec;
        fail_vec_snap_reg <= fail_vec;
        pass_snap_reg     <= pass;
        fail_snap_reg     <= fail;
      end
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_idx_next = byte_idx_reg;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = START_BIT;
          baud_cnt_next = 16'd0;
          bit_cnt_next  = 3'd0;
          byte_idx_next = 4'd0;
          capture       = 1'b1;
        end
      end
      START_BIT: begin
        if (baud_wrap) begin
          state_next    = DATA_BITS;
          baud_cnt_next = 16'd0;
          bit_cnt_next  = 3'd0;
        end else begin
          baud_cnt_next = baud_cnt_reg + 16'd1;
        end
      end
      DATA_BITS: begin
        if (baud_wrap) begin
          baud_cnt_next = 16'd0;
          if (bit_cnt_reg == 3'd7) begin
            state_next = STOP_BIT;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 16'd1;
        end
      end
      STOP_BIT: begin
        if (baud_wrap) begin
          baud_cnt_next = 16'd0;
          if (byte_idx_reg == LAST_BYTE) begin
            state_next = IDLE;
          end else begin
            byte_idx_next = byte_idx_reg + 4'd1;
            state_next    = START_BIT;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is going,
  // so tx/busy/done change on the same edge as the state itself.
  // The byte index only moves on a STOP->START step, so cur_byte is already
  // correct whenever the next state is DATA_BITS.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state_reg == STOP_BIT) && (state_next == IDLE);
    case (state_next)
      START_BIT: tx_next = 1'b0;
      DATA_BITS: tx_next = cur_byte[bit_cnt_next];
      default:   tx_next = 1'b1;
    endcase
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
